// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
//   Frame sequencer for a convolutional encoder / Viterbi decoder loopback.
//   Streams FRAME_LEN payload bits from a source into the encoder, keeps a
//   copy of each sent bit in a small reference buffer, then drives zero tail
//   bits to terminate the trellis and flush the decoder.  Decoded bits that
//   come back DEC_LAT cycles later are compared with the reference copy and
//   the mismatches are counted.  Tail (flush) bits are never compared.
//
//   Optional feature: define VITERBI_FRAME_CTRL_ERR_INJ_EN to enable the
//   periodic channel-error injector on flip_o.  Without it flip_o is tied 0.
//
// Ports
//   clk          clock, all state on rising edge
//   rst          asynchronous, active-low reset
//   start_i      start one frame (sampled only in IDLE)
//   src_valid_i  payload bit available
//   src_bit_i    payload bit
//   src_ready_o  payload bit consumed this cycle
//   enc_en_o     encoder enable
//   enc_bit_o    encoder input bit
//   dec_bit_i    decoder output bit
//   flip_o       invert both channel symbols for this encoder cycle
//   busy_o       frame in progress
//   done_o       one-cycle frame-complete pulse
//   underrun_o   last frame aborted on source underrun
//   err_cnt_o    bit errors in last frame (saturating)
module viterbi_frame_ctrl #(
  parameter int unsigned FRAME_LEN   = 256,
  parameter int unsigned DEC_LAT     = 40,
  parameter int unsigned REF_DEPTH   = 64,
  parameter int unsigned FLIP_PERIOD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        src_valid_i,
  input  logic        src_bit_i,
  output logic        src_ready_o,
  output logic        enc_en_o,
  output logic        enc_bit_o,
  input  logic        dec_bit_i,
  output logic        flip_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        underrun_o,
  output logic [15:0] err_cnt_o
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);
  localparam int unsigned TW = $clog2(DEC_LAT + 1);
  localparam int unsigned PW = (REF_DEPTH > 1) ? $clog2(REF_DEPTH) : 1;

  // Elaboration-time parameter sanity checks.
  if (FRAME_LEN < 1 || FRAME_LEN > 4095) begin : g_bad_frame_len
    $error("viterbi_frame_ctrl: FRAME_LEN out of range");
  end
  if (DEC_LAT < 1 || DEC_LAT >= REF_DEPTH) begin : g_bad_dec_lat
    $error("viterbi_frame_ctrl: DEC_LAT must be 1..REF_DEPTH-1");
  end
  if ((REF_DEPTH & (REF_DEPTH - 1)) != 0) begin : g_bad_ref_depth
    $error("viterbi_frame_ctrl: REF_DEPTH must be a power of 2");
  end
  if (FLIP_PERIOD < 2 || FLIP_PERIOD > 255) begin : g_bad_flip_period
    $error("viterbi_frame_ctrl: FLIP_PERIOD must be 2..255");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    FLUSH   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] tx_cnt;
  logic [CW-1:0] rx_cnt;
  logic [TW-1:0] t_cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ref_mem [REF_DEPTH];

  logic frame_start;
  logic active;
  logic accept;
  logic cmp_en;
  logic mismatch;

  assign frame_start = (state == IDLE) && start_i;
  assign active      = (state == PAYLOAD) || (state == FLUSH);
  assign accept      = (state == PAYLOAD) && src_valid_i;

  // t_cnt saturates at DEC_LAT, so "t >= DEC_LAT" reduces to equality.
  assign cmp_en   = active && (t_cnt == TW'(DEC_LAT)) && (rx_cnt < CW'(FRAME_LEN));
  assign mismatch = cmp_en && (dec_bit_i != ref_mem[rd_ptr]);

  // Next state and combinational outputs.
  always_comb begin
    state_nxt   = state;
    src_ready_o = 1'b0;
    enc_en_o    = 1'b0;
    enc_bit_o   = 1'b0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) state_nxt = PAYLOAD;
      end
      PAYLOAD: begin
        busy_o      = 1'b1;
        src_ready_o = 1'b1;
        enc_en_o    = src_valid_i;
        enc_bit_o   = src_bit_i;
        if (!src_valid_i) begin
          state_nxt = DONE;
        end else if (tx_cnt == CW'(FRAME_LEN - 1)) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy_o   = 1'b1;
        enc_en_o = 1'b1;
        // Compares always lag the payload by DEC_LAT >= 1, so the last one
        // lands here rather than in PAYLOAD.
        if (cmp_en && (rx_cnt == CW'(FRAME_LEN - 1))) state_nxt = DONE;
      end
      DONE: begin
        busy_o    = 1'b1;
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counters, pointers and frame status.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      t_cnt      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_cnt_o  <= '0;
      underrun_o <= 1'b0;
    end else if (frame_start) begin
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      t_cnt      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      err_cnt_o  <= '0;
      underrun_o <= 1'b0;
    end else begin
      if (accept) begin
        tx_cnt <= tx_cnt + 1'b1;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (active && (t_cnt != TW'(DEC_LAT))) begin
        t_cnt <= t_cnt + 1'b1;
      end
      if (cmp_en) begin
        rx_cnt <= rx_cnt + 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (mismatch && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + 16'd1;
      end
      if ((state == PAYLOAD) && !src_valid_i) begin
        underrun_o <= 1'b1;
      end
    end
  end

  // Sent-bit reference buffer; contents need no reset since the pointers do.
  always_ff @(posedge clk) begin
    if (accept) ref_mem[wr_ptr] <= src_bit_i;
  end

`ifdef VITERBI_FRAME_CTRL_ERR_INJ_EN
  // Enabled-symbol counter kept modulo FLIP_PERIOD.
  logic [7:0] sym_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_cnt <= '0;
    end else if (frame_start) begin
      sym_cnt <= '0;
    end else if (enc_en_o) begin
      sym_cnt <= (sym_cnt == 8'(FLIP_PERIOD - 1)) ? '0 : sym_cnt + 8'd1;
    end
  end

  assign flip_o = enc_en_o && (sym_cnt == 8'(FLIP_PERIOD - 1));
`else
  assign flip_o = 1'b0;
`endif

endmodule
